// File: rtl/softmax_tile_feeder_if.sv
// Links the score source, the tile feeder and the softmax engine.
// The feeder connects through the master modport.
interface softmax_tile_feeder_if #(
    parameter int WIDTH     = 32,
    parameter int TILE_SIZE = 8
);
    logic                       row_start;
    logic [WIDTH-1:0]           elem_in;
    logic                       elem_valid;
    logic                       elem_last;
    logic                       elem_ready;
    logic                       sm_start;
    logic [TILE_SIZE*WIDTH-1:0] tile_out;
    logic                       tile_valid;
    logic                       sm_done;
    logic                       busy;
    logic                       err_len;
    logic [2:0]                 fsm_state;

    // elem_in transfers on every cycle with elem_valid && elem_ready; tile_valid is a strobe with no backpressure.
    modport master (
        input  row_start, elem_in, elem_valid, elem_last, sm_done,
        output elem_ready, sm_start, tile_out, tile_valid, busy, err_len, fsm_state
    );

    modport slave (
        output row_start, elem_in, elem_valid, elem_last, sm_done,
        input  elem_ready, sm_start, tile_out, tile_valid, busy, err_len, fsm_state
    );
endinterface

// File: rtl/softmax_tile_feeder.sv
// Packs a row of scalar scores into fixed-width tiles for the softmax engine.
// Short rows are padded, and length errors are flagged.
module softmax_tile_feeder #(
    parameter int               WIDTH          = 32,
    parameter int               TILE_SIZE      = 8,
    parameter int               TOTAL_ELEMENTS = 64,
    parameter logic [WIDTH-1:0] PAD_VALUE      = 32'hC000_0000
) (
    input logic                   clk,
    input logic                   rst_n,
    input logic                   en,
    softmax_tile_feeder_if.master bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        PACK      = 3'd2,
        FLUSH     = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    localparam int NTILES = (TOTAL_ELEMENTS + TILE_SIZE - 1) / TILE_SIZE;
    localparam int CNT_W  = $clog2(TOTAL_ELEMENTS + 1);
    localparam int LANE_W = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
    localparam int TCNT_W = $clog2(NTILES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TOTAL_ELEMENTS - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(TILE_SIZE - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(NTILES - 1);
    localparam logic [TCNT_W-1:0] TCNT_ALL  = TCNT_W'(NTILES);

    state_t                     state, state_d;
    logic [CNT_W-1:0]           elem_cnt, elem_cnt_d;
    logic [LANE_W-1:0]          lane, lane_d;
    logic [TCNT_W-1:0]          tile_cnt, tile_cnt_d;
    logic [WIDTH-1:0]           pack   [TILE_SIZE];
    logic [WIDTH-1:0]           pack_d [TILE_SIZE];
    logic [TILE_SIZE*WIDTH-1:0] tile_q, tile_d, flat;
    logic                       ready_q, ready_d;
    logic                       start_q, start_d;
    logic                       valid_q, valid_d;
    logic                       busy_q, busy_d;
    logic                       err_q, err_d;
    logic                       accept;

    assign accept = (state == PACK) && ready_q && en && bus.elem_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            elem_cnt <= '0;
            lane     <= '0;
            tile_cnt <= '0;
            for (int k = 0; k < TILE_SIZE; k++) pack[k] <= PAD_VALUE;
            tile_q   <= '0;
            ready_q  <= 1'b0;
            start_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (en) begin
            state    <= state_d;
            elem_cnt <= elem_cnt_d;
            lane     <= lane_d;
            tile_cnt <= tile_cnt_d;
            for (int k = 0; k < TILE_SIZE; k++) pack[k] <= pack_d[k];
            tile_q   <= tile_d;
            ready_q  <= ready_d;
            start_q  <= start_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d    = state;
        elem_cnt_d = elem_cnt;
        lane_d     = lane;
        tile_cnt_d = tile_cnt;
        pack_d     = pack;
        tile_d     = tile_q;
        start_d    = 1'b0;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        flat       = '0;

        // The tile built here already includes the element accepted this cycle.
        if (accept) pack_d[lane] = bus.elem_in;
        for (int k = 0; k < TILE_SIZE; k++) flat[(TILE_SIZE-1-k)*WIDTH +: WIDTH] = pack_d[k];

        case (state)
            IDLE: begin
                if (bus.row_start) begin
                    state_d    = ARM;
                    elem_cnt_d = '0;
                    lane_d     = '0;
                    tile_cnt_d = '0;
                    for (int k = 0; k < TILE_SIZE; k++) pack_d[k] = PAD_VALUE;
                end
            end
            ARM: begin
                start_d = 1'b1;
                state_d = PACK;
            end
            PACK: begin
                if (accept) begin
                    elem_cnt_d = elem_cnt + 1'b1;
                    lane_d     = lane + 1'b1;
                    if (lane == LANE_LAST || elem_cnt == CNT_LAST || bus.elem_last) begin
                        tile_d     = flat;
                        valid_d    = 1'b1;
                        lane_d     = '0;
                        tile_cnt_d = tile_cnt + 1'b1;
                        for (int k = 0; k < TILE_SIZE; k++) pack_d[k] = PAD_VALUE;
                    end
                    if (elem_cnt == CNT_LAST) begin
                        state_d = WAIT_DONE;
                        err_d   = !bus.elem_last;
                    end else if (bus.elem_last) begin
                        state_d = FLUSH;
                        err_d   = 1'b1;
                    end
                end
            end
            FLUSH: begin
                // The engine always expects a full row's worth of tiles.
                if (tile_cnt < TCNT_ALL) begin
                    tile_d     = {TILE_SIZE{PAD_VALUE}};
                    valid_d    = 1'b1;
                    tile_cnt_d = tile_cnt + 1'b1;
                    if (tile_cnt == TCNT_LAST) state_d = WAIT_DONE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.sm_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state == PACK) && (state_d == PACK);
        busy_d  = (state_d != IDLE);
    end

    assign bus.elem_ready = ready_q & en;
    assign bus.sm_start   = start_q & en;
    assign bus.tile_valid = valid_q & en;
    assign bus.tile_out   = tile_q;
    assign bus.busy       = busy_q;
    assign bus.err_len    = err_q;
    assign bus.fsm_state  = state;
endmodule

// File: tb/tb_softmax_tile_feeder.sv
// Bench for softmax_tile_feeder with TOTAL_ELEMENTS=20, a row length that does not fill the last tile.
// Expected tiles come from a lane-array model of the row.
module tb_softmax_tile_feeder;
  localparam int W = 32;
  localparam int TILE = 8;
  localparam int TOTAL = 20;
  localparam int NT = (TOTAL + TILE - 1) / TILE;
  localparam int TW = TILE * W;
  localparam logic [W-1:0] PAD = 32'hC000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  always #5 clk = ~clk;

  softmax_tile_feeder_if #(.WIDTH(W), .TILE_SIZE(TILE)) bus ();

  softmax_tile_feeder #(
    .WIDTH(W), .TILE_SIZE(TILE), .TOTAL_ELEMENTS(TOTAL), .PAD_VALUE(PAD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus)
  );

  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] got_q[$];
  logic [W-1:0] row_vals[$];
  int n_checks = 0;
  int n_errors = 0;
  int row_tiles, err_seen, start_seen;

  typedef struct {
    int n;
    bit last;
    bit gaps;
    int en_hold;
    bit extra;
    bit exp_err;
    int exp_tiles;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Row model: lay the scores out in lane order, pad to whole tiles, slice.
  task automatic model_row();
    logic [W-1:0] lanes[$];
    logic [TW-1:0] t;
    lanes = row_vals;
    while (lanes.size() < NT * TILE) lanes.push_back(PAD);
    for (int i = 0; i < NT; i++) begin
      t = '0;
      for (int k = 0; k < TILE; k++) t[(TILE-1-k)*W +: W] = lanes[i*TILE+k];
      exp_q.push_back(t);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.tile_valid) begin
        row_tiles++;
        got_q.push_back(bus.tile_out);
        check("tile_valid_gated_by_en", en, 1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_tile: got %0h want none", bus.tile_out);
        end else begin
          check("tile_data", bus.tile_out, exp_q.pop_front());
        end
      end
      if (en && bus.err_len) err_seen++;
      if (bus.sm_start) start_seen++;
    end
  end

  task automatic start_row();
    bus.row_start = 1'b1;
    @(negedge clk);
    check("idle_before_start", bus.fsm_state, 0);
    step();
    bus.row_start = 1'b0;
    @(negedge clk);
    check("arm_state", bus.fsm_state, 1);
    check("arm_busy", bus.busy, 1);
    check("arm_no_start", bus.sm_start, 0);
    step();
    @(negedge clk);
    check("sm_start_pulse", bus.sm_start, 1);
    check("no_ready_with_start", bus.elem_ready, 0);
    step();
  endtask

  task automatic send_elem(input logic [W-1:0] v, input bit last, output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    bus.elem_in = v;
    bus.elem_valid = 1'b1;
    bus.elem_last = last;
    while (!done && waits < 100) begin
      @(negedge clk);
      if (bus.elem_ready) done = 1'b1;
      else waits++;
      step();
    end
    if (!done) check("accept_timeout", done, 1);
    bus.elem_valid = 1'b0;
    bus.elem_last = 1'b0;
  endtask

  task automatic run_row(input int n, input bit last, input bit gaps, input int en_hold,
                         input bit extra, input bit rnd);
    int waits, w;
    row_vals.delete();
    got_q.delete();
    row_tiles = 0;
    err_seen = 0;
    start_seen = 0;
    for (int i = 0; i < n; i++) row_vals.push_back(rnd ? W'($urandom) : W'(i + 1));
    model_row();
    start_row();
    waits = 0;
    for (int i = 0; i < n; i++) begin
      if (i == en_hold) begin
        en = 1'b0;
        bus.elem_in = row_vals[i];
        bus.elem_valid = 1'b1;
        repeat (5) begin
          @(negedge clk);
          check("ready_while_en_low", bus.elem_ready, 0);
          step();
        end
        en = 1'b1;
      end
      if (gaps) begin
        bus.elem_valid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
      end
      send_elem(row_vals[i], last && (i == n - 1), w);
      waits += w;
    end
    if (!gaps && en_hold < 0) check("full_rate_waits", waits, 0);
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      step();
      w++;
    end
    check("tiles_drained", exp_q.size(), 0);
    @(negedge clk);
    check("wait_done_state", bus.fsm_state, 4);
    check("wait_done_busy", bus.busy, 1);
    check("wait_done_no_ready", bus.elem_ready, 0);
    step();
    if (extra) begin
      bus.elem_valid = 1'b1;
      bus.elem_in = W'($urandom);
      bus.row_start = 1'b1;
      step();
      bus.row_start = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check("extra_elem_not_accepted", bus.elem_ready, 0);
        step();
      end
    end
    bus.sm_done = 1'b1;
    step();
    bus.sm_done = 1'b0;
    bus.elem_valid = 1'b0;
    @(negedge clk);
    check("idle_after_done_state", bus.fsm_state, 0);
    check("idle_after_done_busy", bus.busy, 0);
    if (extra) begin
      step();
      @(negedge clk);
      check("row_start_not_queued", bus.busy, 0);
    end
    check("sm_start_count", start_seen, 1);
    check("tile_count", row_tiles, NT);
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [TW-1:0] want;
    int n, w;
    bit last;
    bus.row_start = 1'b0;
    bus.elem_in = '0;
    bus.elem_valid = 1'b0;
    bus.elem_last = 1'b0;
    bus.sm_done = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("rst_elem_ready", bus.elem_ready, 0);
    check("rst_sm_start", bus.sm_start, 0);
    check("rst_tile_valid", bus.tile_valid, 0);
    check("rst_tile_out", bus.tile_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err_len", bus.err_len, 0);
    check("rst_state", bus.fsm_state, 0);
    step();
    rst_n = 1'b1;
    step();

    //        n      last  gaps  en_hold extra exp_err tiles
    vecs[0] = '{TOTAL, 1'b1, 1'b0, -1,    1'b0, 1'b0,   NT};
    vecs[1] = '{10,    1'b1, 1'b0, -1,    1'b0, 1'b1,   NT};
    vecs[2] = '{TOTAL, 1'b0, 1'b0, -1,    1'b1, 1'b1,   NT};
    vecs[3] = '{TOTAL, 1'b1, 1'b1, 8,     1'b0, 1'b0,   NT};
    vecs[4] = '{1,     1'b1, 1'b0, -1,    1'b0, 1'b1,   NT};
    vecs[5] = '{8,     1'b1, 1'b0, -1,    1'b0, 1'b1,   NT};
    vecs[6] = '{19,    1'b1, 1'b1, -1,    1'b0, 1'b1,   NT};
    vecs[7] = '{16,    1'b1, 1'b0, -1,    1'b1, 1'b1,   NT};

    for (int v = 0; v < 8; v++) begin
      run_row(vecs[v].n, vecs[v].last, vecs[v].gaps, vecs[v].en_hold, vecs[v].extra, 1'b0);
      check("err_len_count", err_seen, vecs[v].exp_err);
      check("row_tiles", row_tiles, vecs[v].exp_tiles);
      if (v == 0) begin
        want = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        check("full_row_tile0", got_q[0], want);
        want = {32'd17, 32'd18, 32'd19, 32'd20, PAD, PAD, PAD, PAD};
        check("full_row_tile2", got_q[2], want);
      end
      if (v == 1) begin
        want = {32'd9, 32'd10, PAD, PAD, PAD, PAD, PAD, PAD};
        check("short_row_tile1", got_q[1], want);
        want = {PAD, PAD, PAD, PAD, PAD, PAD, PAD, PAD};
        check("short_row_pad_tile", got_q[2], want);
      end
    end

    // Abort a row with reset after five elements.
    row_vals.delete();
    for (int i = 0; i < 5; i++) row_vals.push_back(W'(100 + i));
    start_row();
    for (int i = 0; i < 5; i++) send_elem(row_vals[i], 1'b0, w);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("abort_elem_ready", bus.elem_ready, 0);
    check("abort_sm_start", bus.sm_start, 0);
    check("abort_tile_valid", bus.tile_valid, 0);
    check("abort_tile_out", bus.tile_out, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_err_len", bus.err_len, 0);
    check("abort_state", bus.fsm_state, 0);
    step();
    run_row(3, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    check("after_abort_err", err_seen, 1);
    want = {32'd1, 32'd2, 32'd3, PAD, PAD, PAD, PAD, PAD};
    check("after_abort_tile0", got_q[0], want);

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, TOTAL);
      last = (n < TOTAL) ? 1'b1 : 1'($urandom_range(0, 1));
      run_row(n, last, 1'($urandom_range(0, 1)), -1, 1'b0, 1'b1);
      check("rand_err_len", err_seen, (n == TOTAL && last) ? 0 : 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
